// File: rtl/buf_rd_32x64_pkg.sv
// Shared definitions for the burst RAM reader: default widths and the FSM
// state encoding.
package buf_rd_32x64_pkg;

  localparam int ADR_WD_DEF = 5;   // 32-word RAM
  localparam int DAT_WD_DEF = 64;  // 64-bit RAM word

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/buf_rd_32x64_fifo_2xN.sv
// Two-entry output FIFO. The head word is presented directly on o_dat, so it
// stays stable while the consumer stalls.
module fifo_2xN
  import buf_rd_32x64_pkg::*;
#(
  parameter int DAT_WD = DAT_WD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DAT_WD-1:0] i_dat,
  input  logic              i_pop,
  output logic [DAT_WD-1:0] o_dat,
  output logic              o_val,
  output logic [1:0]        o_cnt
);

  logic [DAT_WD-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_cnt;

  // Storage, pointers and occupancy; push and pop may happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only two words, and the head must read as zero out of reset,
      // so the storage is reset along with the pointers.
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_dat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;  // idle, or push and pop cancel out
      endcase
    end
  end

  assign o_dat = r_mem[r_rd_ptr];
  assign o_val = (r_cnt != 2'd0);
  assign o_cnt = r_cnt;

endmodule

// File: rtl/buf_rd_32x64.sv
// Burst reader for the read side of a 32x64 two-port RAM. Issues len reads
// from base (wrapping), buffers the returning data in a 2-entry FIFO and
// streams it out with valid/ready, flagging the last word.
module buf_rd_32x64
  import buf_rd_32x64_pkg::*;
#(
  parameter int ADR_WD = ADR_WD_DEF,
  parameter int DAT_WD = DAT_WD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADR_WD-1:0] base_adr_i,
  input  logic [ADR_WD:0]   len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_ena_o,
  output logic [ADR_WD-1:0] rd_adr_o,
  input  logic [DAT_WD-1:0] rd_dat_i,
  output logic              dat_val_o,
  input  logic              dat_rdy_i,
  output logic [DAT_WD-1:0] dat_o,
  output logic              dat_lst_o
);

  localparam logic [ADR_WD:0]   LEN_ONE = (ADR_WD + 1)'(1);
  localparam logic [ADR_WD-1:0] ADR_ONE = ADR_WD'(1);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_inflight;  // a read was issued last cycle; its data is on rd_dat_i now
  logic [ADR_WD:0]   r_len;
  logic [ADR_WD:0]   r_iss_cnt;   // reads issued in this burst
  logic [ADR_WD:0]   r_out_cnt;   // words transferred in this burst
  logic [ADR_WD-1:0] r_adr;

  logic              w_fifo_val;
  logic [1:0]        w_fifo_cnt;
  logic [DAT_WD-1:0] w_fifo_dat;
  logic              w_pop;
  logic              w_credit_ok;
  logic              w_rd_ena;
  logic              w_lst;

  assign w_pop = w_fifo_val & dat_rdy_i;

  // A read may issue only if, counting the word still in flight and the word
  // leaving this cycle, the FIFO will have room when its data returns.
  assign w_credit_ok = ({1'b0, w_fifo_cnt} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
  assign w_rd_ena    = (r_state == ST_READ) && (r_iss_cnt != r_len) && w_credit_ok;
  assign w_lst       = w_fifo_val && (r_out_cnt == r_len - LEN_ONE);

  // Burst FSM with its counters, address and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_inflight <= 1'b0;
      r_len      <= '0;
      r_iss_cnt  <= '0;
      r_out_cnt  <= '0;
      r_adr      <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every branch below sees the values
      // from before this edge regardless of statement order.
      r_inflight <= w_rd_ena;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_len     <= len_i;
            r_adr     <= base_adr_i;
            r_iss_cnt <= '0;
            r_out_cnt <= '0;
            if (len_i == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_READ;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (w_rd_ena) begin
            r_adr     <= r_adr + ADR_ONE;
            r_iss_cnt <= r_iss_cnt + LEN_ONE;
            if (r_iss_cnt == r_len - LEN_ONE) r_state <= ST_DRAIN;
          end
          // The last word can never leave while reads are still pending.
          if (w_pop) r_out_cnt <= r_out_cnt + LEN_ONE;
        end
        ST_DRAIN: begin
          if (w_pop) begin
            r_out_cnt <= r_out_cnt + LEN_ONE;
            if (w_lst) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin  // ST_DONE
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  fifo_2xN #(
    .DAT_WD (DAT_WD)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_inflight),
    .i_dat  (rd_dat_i),
    .i_pop  (w_pop),
    .o_dat  (w_fifo_dat),
    .o_val  (w_fifo_val),
    .o_cnt  (w_fifo_cnt)
  );

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign rd_ena_o  = w_rd_ena;
  assign rd_adr_o  = r_adr;
  assign dat_val_o = w_fifo_val;
  assign dat_o     = w_fifo_dat;
  assign dat_lst_o = w_lst;

endmodule

// File: tb/tb_buf_rd_32x64.sv
// Scoreboard bench for buf_rd_32x64: stimulus pushes expected words, a
// negedge monitor pops and compares every transferred word.
module tb_buf_rd_32x64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [4:0]  base_adr_i = '0;
  logic [5:0]  len_i = '0;
  logic        busy_o, done_o, rd_ena_o, dat_val_o, dat_lst_o;
  logic [4:0]  rd_adr_o;
  logic [63:0] rd_dat_i;
  logic        dat_rdy_i = 1'b1;
  logic [63:0] dat_o;

  typedef struct packed {
    logic [63:0] dat;
    logic        lst;
  } exp_t;

  exp_t       sb_q[$];
  logic [4:0] adr_log[$];
  logic [4:0] exp_adr[$];

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int first_rd_cyc = -1;
  int first_val_cyc = -1;
  int last_xfer_cyc = -1;
  int n_rd = 0;
  int n_xfer = 0;
  bit busy_seen = 1'b0;
  int rdy_mode = 0;  // 0: ready high, 1: toggle each cycle, 2: ready low

  bit          hold_v = 1'b0;
  logic [63:0] hold_dat = '0;
  logic        hold_lst = 1'b0;

  buf_rd_32x64 dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .base_adr_i (base_adr_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rd_ena_o   (rd_ena_o),
    .rd_adr_o   (rd_adr_o),
    .rd_dat_i   (rd_dat_i),
    .dat_val_o  (dat_val_o),
    .dat_rdy_i  (dat_rdy_i),
    .dat_o      (dat_o),
    .dat_lst_o  (dat_lst_o)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Low half of each RAM word is its address; high half is the complement.
  function automatic logic [63:0] ram_word(input logic [4:0] a);
    return {~(32'(a)), 32'(a)};
  endfunction

  // RAM read side: one-cycle latency, junk whenever no read was issued.
  always @(posedge clk)
    rd_dat_i <= rd_ena_o ? ram_word(rd_adr_o) : 64'hBAD0_BAD0_BAD0_BAD0;

  // Downstream ready pattern.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1:       dat_rdy_i = ~dat_rdy_i;
      2:       dat_rdy_i = 1'b0;
      default: dat_rdy_i = 1'b1;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pop, hold stability, credit bound, event timestamps.
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy_o) busy_seen = 1'b1;
      if (rd_ena_o) begin
        n_rd++;
        adr_log.push_back(rd_adr_o);
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (dat_val_o && first_val_cyc < 0) first_val_cyc = cyc;
      if (hold_v && dat_val_o) begin
        check("hold_dat", dat_o, hold_dat);
        check("hold_lst", 64'(dat_lst_o), 64'(hold_lst));
      end
      hold_v   = dat_val_o && !dat_rdy_i;
      hold_dat = dat_o;
      hold_lst = dat_lst_o;
      if (dat_val_o && dat_rdy_i) begin
        n_xfer++;
        last_xfer_cyc = cyc;
        if (sb_q.size() == 0) begin
          check("unexpected_word", dat_o, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("word_dat", dat_o, e.dat);
          check("word_lst", 64'(dat_lst_o), 64'(e.lst));
        end
      end
      if (rd_ena_o) check("credit_le_2", 64'((n_rd - n_xfer) <= 2), 64'(1));
    end
  end

  task automatic clear_obs();
    first_rd_cyc  = -1;
    first_val_cyc = -1;
    last_xfer_cyc = -1;
    n_rd          = 0;
    n_xfer        = 0;
    busy_seen     = 1'b0;
    adr_log.delete();
  endtask

  task automatic do_start(input logic [4:0] base, input int len, output int c0);
    @(posedge clk);
    #1;
    clear_obs();
    start_i    = 1'b1;
    base_adr_i = base;
    len_i      = 6'(len);
    c0         = cyc;
    for (int k = 0; k < len; k++) begin
      exp_t e;
      e.dat = ram_word(base + 5'(k));
      e.lst = (k == len - 1);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(name, 64'(done_cnt), 64'(target));
  endtask

  task automatic check_adrs(input string name);
    check({name, "_rd_count"}, 64'(adr_log.size()), 64'(exp_adr.size()));
    for (int i = 0; i < exp_adr.size() && i < adr_log.size(); i++)
      check({name, "_rd_adr"}, 64'(adr_log[i]), 64'(exp_adr[i]));
  endtask

  initial begin
    int c0;
    int d0;

    // Reset state, observed while rst is still high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_rd_ena", 64'(rd_ena_o), 64'(0));
    check("rst_val", 64'(dat_val_o), 64'(0));
    check("rst_lst", 64'(dat_lst_o), 64'(0));
    check("rst_rd_adr", 64'(rd_adr_o), 64'(0));
    check("rst_dat", dat_o, 64'(0));
    rst = 1'b0;

    // base 0, len 4, ready high: reads from cycle 1, words on 3..6, done at 7.
    do_start(5'd0, 4, c0);
    wait_done("s36_done", 1, 40);
    check("s36_first_rd", 64'(first_rd_cyc - c0), 64'(1));
    check("s36_first_val", 64'(first_val_cyc - c0), 64'(3));
    check("s36_last_xfer", 64'(last_xfer_cyc - c0), 64'(6));
    check("s36_done_cyc", 64'(done_cyc - c0), 64'(7));
    check("s36_words", 64'(n_xfer), 64'(4));
    exp_adr = '{5'd0, 5'd1, 5'd2, 5'd3};
    check_adrs("s36");
    @(negedge clk);
    #1;
    check("s36_done_pulse_width", 64'(done_o), 64'(0));

    // base 30, len 4: address wraps 31 -> 0.
    do_start(5'd30, 4, c0);
    wait_done("s37_done", 2, 40);
    exp_adr = '{5'd30, 5'd31, 5'd0, 5'd1};
    check_adrs("s37");

    // len 8 with ready held low first (FIFO fills), then toggling.
    rdy_mode = 2;
    do_start(5'd5, 8, c0);
    repeat (5) @(negedge clk);
    #1;
    check("s38_full_no_rd", 64'(rd_ena_o), 64'(0));
    check("s38_full_val", 64'(dat_val_o), 64'(1));
    check("s38_full_rd_count", 64'(n_rd), 64'(2));
    rdy_mode = 1;
    wait_done("s38_done", 3, 80);
    check("s38_words", 64'(n_xfer), 64'(8));
    exp_adr = '{5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
    check_adrs("s38");
    rdy_mode = 0;

    // len 0: no reads, done one cycle after start, never busy.
    do_start(5'd9, 0, c0);
    wait_done("s39_done", 4, 20);
    check("s39_done_cyc", 64'(done_cyc - c0), 64'(1));
    check("s39_no_rd", 64'(n_rd), 64'(0));
    check("s39_never_busy", 64'(busy_seen), 64'(0));

    // Reset on cycle 5 of a len 16 burst, then a len 2 burst.
    do_start(5'd10, 16, c0);
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1;
    check("s40_rst_cycle", 64'(cyc - c0), 64'(5));
    d0  = done_cnt;
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("s40_busy", 64'(busy_o), 64'(0));
    check("s40_done", 64'(done_o), 64'(0));
    check("s40_rd_ena", 64'(rd_ena_o), 64'(0));
    check("s40_val", 64'(dat_val_o), 64'(0));
    check("s40_lst", 64'(dat_lst_o), 64'(0));
    check("s40_rd_adr", 64'(rd_adr_o), 64'(0));
    check("s40_dat", dat_o, 64'(0));
    repeat (4) @(negedge clk);
    #1;
    check("s40_no_done", 64'(done_cnt), 64'(d0));
    check("s40_no_stale_word", 64'(dat_val_o), 64'(0));
    do_start(5'd3, 2, c0);
    wait_done("s40_restart_done", d0 + 1, 30);
    check("s40_restart_words", 64'(n_xfer), 64'(2));
    exp_adr = '{5'd3, 5'd4};
    check_adrs("s40");

    // start_i while busy is ignored.
    d0 = done_cnt;
    do_start(5'd20, 3, c0);
    @(posedge clk);
    #1;
    start_i    = 1'b1;
    base_adr_i = 5'd0;
    len_i      = 6'd5;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done("s41_done", d0 + 1, 30);
    check("s41_words", 64'(n_xfer), 64'(3));
    exp_adr = '{5'd20, 5'd21, 5'd22};
    check_adrs("s41");
    repeat (6) @(negedge clk);
    #1;
    check("s41_no_extra_done", 64'(done_cnt), 64'(d0 + 1));
    check("s41_idle_busy", 64'(busy_o), 64'(0));
    check("s41_no_extra_words", 64'(n_xfer), 64'(3));

    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
